// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, strobes the combinational instruction ROM and
// registers each fetched word into IR, with sequential/branch/jump/jump-register redirects.
module inst_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ROM_BYTES = 100
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               PCWre,
  input  logic [1:0]         PCSrc,
  input  logic signed [31:0] Imm,
  input  logic [25:0]        JTarget,
  input  logic [31:0]        RegTarget,
  input  logic               Halt,
  output logic               nRD,
  output logic [31:0]        IAddr,
  input  logic [31:0]        IDataIn,
  output logic [31:0]        PC,
  output logic [31:0]        IR,
  output logic [31:0]        IRPC,
  output logic               IRValid,
  output logic               AddrErr,
  output logic               Halted
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_STALL = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_p0;
  logic [31:0] ir_p1;
  logic [31:0] irpc_p1;
  logic        vld_p1;
  logic        aerr_p1;
  logic        in_range;
  logic        halt_req;
  logic [1:0]  src_eff;
  logic [31:0] pc_nxt;

  // Redirect targets are formed from IRPC (the instruction being decoded), not from PC.
  function automatic logic [31:0] next_pc(
    input logic [1:0]         src,
    input logic [31:0]        pc,
    input logic [31:0]        irpc,
    input logic signed [31:0] imm,
    input logic [25:0]        jt,
    input logic [31:0]        rt
  );
    logic [31:0] irpc4;
    logic [31:0] res;
    irpc4 = irpc + 32'd4;
    case (src)
      2'b01:   res = irpc4 + $unsigned(imm <<< 2);
      2'b10:   res = {rt[31:2], 2'b00};
      2'b11:   res = {irpc4[31:28], jt, 2'b00};
      default: res = pc + 32'd4;
    endcase
    return res;
  endfunction

  // Widened compare so a PC near the top of the address space cannot wrap into range.
  assign in_range = ({1'b0, pc_p0} + 33'd3) < 33'(ROM_BYTES);
  assign halt_req = Halt && vld_p1;
  assign src_eff  = vld_p1 ? PCSrc : 2'b00;
  assign pc_nxt   = next_pc(src_eff, pc_p0, irpc_p1, Imm, JTarget, RegTarget);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_FETCH;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_HALT: state_nxt = S_HALT;
      default: begin
        if (halt_req)    state_nxt = S_HALT;
        else if (!PCWre) state_nxt = S_STALL;
        else             state_nxt = S_FETCH;
      end
    endcase
  end

  always_comb begin
    Halted = (state == S_HALT);
    nRD    = (state == S_HALT) || !in_range;
  end

  // Fetch stage boundary: PC and IR update on the same edge, one cycle PC-to-IR latency.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pc_p0   <= RESET_PC;
      ir_p1   <= 32'd0;
      irpc_p1 <= 32'd0;
      vld_p1  <= 1'b0;
      aerr_p1 <= 1'b0;
    end else if (state != S_HALT) begin
      aerr_p1 <= 1'b0;
      if (halt_req) begin
        ir_p1  <= 32'd0;
        vld_p1 <= 1'b0;
      end else if (PCWre) begin
        ir_p1   <= in_range ? IDataIn : 32'd0;
        irpc_p1 <= pc_p0;
        vld_p1  <= in_range;
        pc_p0   <= pc_nxt;
        aerr_p1 <= (src_eff == 2'b10) && (RegTarget[1:0] != 2'b00);
      end
    end else begin
      aerr_p1 <= 1'b0;
    end
  end

  assign PC      = pc_p0;
  assign IAddr   = pc_p0;
  assign IR      = ir_p1;
  assign IRPC    = irpc_p1;
  assign IRValid = vld_p1;
  assign AddrErr = aerr_p1;

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit: the initiator side of the byte-addressed, big-endian instruction ROM interface. It holds the program counter and drives the ROM read strobe and address. It captures each returned 32-bit word into an instruction register for decode, and computes the next PC from sequential, branch, jump and jump-register sources. It sits between the ROM and the decoder/control unit of the single-issue MIPS core.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `ROM_BYTES`, default 100: ROM size in bytes. Fetches with `PC + 3 >= ROM_BYTES` are out of range.
- `CLK  in  1`: rising-edge clock.
- `RST  in  1`: asynchronous reset, active-low.
- `PCWre  in  1`: advance enable. 0 stalls PC and IR.
- `PCSrc  in  2`: next-PC select.
  - 00: sequential.
  - 01: branch.
  - 10: jump register.
  - 11: jump.
- `Imm  in  32`: sign-extended branch offset, in words.
- `JTarget  in  26`: J-type target field.
- `RegTarget  in  32`: jump-register target.
- `Halt  in  1`: decoder flags the instruction in IR as halt.
- `nRD  out  1`: ROM read strobe, active-low.
- `IAddr  out  32`: ROM byte address; always equals `PC`.
- `IDataIn  in  32`: ROM data, valid combinationally while `nRD`=0.
- `PC  out  32`: current fetch address.
- `IR  out  32`: instruction register.
- `IRPC  out  32`: address of the word held in `IR`.
- `IRValid  out  1`: `IR` holds a real fetched instruction.
- `AddrErr  out  1`: one-cycle pulse on a misaligned jump-register target.
- `Halted  out  1`: high in the HALT state.

## Operation
- States:
  - FETCH: normal operation.
  - STALL: `PCWre`=0 observed.
  - HALT: terminal until reset.
- Reset (async, `RST`=0):
  - `PC`=`RESET_PC`, `IR`=0, `IRPC`=0, `IRValid`=0, `AddrErr`=0, `Halted`=0.
  - State=FETCH; `nRD`=0.
- Read strobe: `nRD`=0 in FETCH/STALL when `PC` is in range; `nRD`=1 in HALT or when out of range.
- Next-PC (all arithmetic mod 2^32, wrap silently):
  - 00: `PC + 4`.
  - 01: `IRPC + 4 + (Imm << 2)`.
  - 10: `{RegTarget[31:2], 2'b00}`.
  - 11: `{(IRPC+4)[31:28], JTarget, 2'b00}`.
- Redirects are relative to `IR`, not `PC`. The word fetched in the cycle a redirect resolves is the delay slot; it is loaded into `IR` and executes.
- When `IRValid`=0, `PCSrc` is ignored and treated as 00.
- Edge priority: `Halt`&&`IRValid` > `PCWre`=0 > advance.
  - Halt: state→HALT, `Halted`=1, `IRValid`←0, `IR`←0. `PC` holds.
  - `PCWre`=0: state→STALL. `PC`, `IR`, `IRPC`, `IRValid` hold.
  - Advance: state→FETCH.
    - `IR`←`IDataIn` (or 0 if out of range).
    - `IRPC`←`PC`.
    - `IRValid`←in-range.
    - `PC`←next-PC.
- Out-of-range fetch: `IR`←0 (nop), `IRValid`←0. `PC` still advances per `PCSrc`, so a redirect already in `IR` can recover.
- `AddrErr`: 1 for exactly the edge after an advance with `PCSrc`=10 and `RegTarget[1:0]`≠0; otherwise 0.
- HALT ignores `PCWre`, `PCSrc` and `Halt`; only `RST` exits.

## Timing
- ROM is combinational. The fetch result is registered on the same edge that `PC` updates, giving 1-cycle latency from `PC` to `IR`.
- `IAddr`/`nRD` change only after a clock edge or reset; no glitch path from `PCSrc`, `Imm` or `RegTarget` to `IAddr`.
- First valid `IR` appears one edge after `RST` deasserts; `IRPC`=`RESET_PC` at that point.
- Stall releases with no bubble: the first edge with `PCWre`=1 captures `IDataIn` at the held `PC`.
- Reset mid-stall or mid-redirect: immediate return to reset values; the pending redirect is discarded.

## Test plan
- Sequential fetch: reset, ROM words W0..W3 at 0,4,8,12.
  - Edges 1–4: `IR`=W0..W3.
  - `IRPC`=0,4,8,12.
  - `PC`=4,8,12,16.
- Branch with delay slot: `IR` at `IRPC`=8, `PCSrc`=01, `Imm`=32'hFFFF_FFFE.
  - Next edge: `IR`=word at 12 (delay slot), `PC`=4.
  - Following edge: `IRPC`=4.
- Jump/jump-register:
  - `PCSrc`=11, `JTarget`=26'h5, `IRPC`=0 → `PC`=32'h14.
  - `PCSrc`=10, `RegTarget`=32'h22 → `PC`=32'h20, `AddrErr`=1 for one cycle.
- Stall: `PCWre`=0 for 3 cycles at `PC`=8.
  - `PC`, `IR`, `IRValid` constant; `nRD`=0.
  - Release: `IR`=word at 8 on the next edge.
- Halt and range:
  - `Halt`=1 with `IRValid`=1 → `Halted`=1, `nRD`=1, `IRValid`=0; the state persists under all inputs until `RST`=0.
  - `PC`=96 with `ROM_BYTES`=100 → `nRD`=0, valid.
  - `PC`=100 → `nRD`=1, `IR`=0, `IRValid`=0.
- Async reset mid-run: assert `RST`=0 between edges.
  - Outputs reach reset values without a clock edge.
  - First fetch after release is from `RESET_PC`.
